// File: rtl/vdma_wr_burst.sv
// VDMA write-side AXI burst engine: turns upstream beat requests
// into AW/W/B bursts fed from a show-ahead FIFO.
module vdma_wr_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LSIZE      = 9,
  parameter int MAX_BURST  = 256
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic [ADDR_WIDTH-1:0]   frame_base,
  input  logic                    burst_req,
  input  logic                    tail_req,
  input  logic [LSIZE-1:0]        req_len,
  output logic                    resp,
  output logic                    done,
  input  logic [DATA_WIDTH-1:0]   fifo_rdata,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int BW    = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [LSIZE-1:0]      remaining;
  logic [LSIZE-1:0]      rem_nxt;
  logic [LSIZE-1:0]      len_src;
  logic [BW-1:0]         beats;
  logic [BW-1:0]         beats_nxt;
  logic [BW-1:0]         cnt;
  logic                  fs_pend;
  logic                  fs_hit;
  logic                  take;
  logic                  ld_aw;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;

  function automatic logic [BW-1:0] clip(
    input logic [LSIZE-1:0] n
  );
    if (32'(n) > MAX_BURST)
      return BW'(MAX_BURST);
    return BW'(n);
  endfunction

  // A pending frame reload always wins over a waiting request
  assign fs_hit = (state == S_IDLE) &&
                  (frame_start || fs_pend);
  assign take   = (state == S_IDLE) && !fs_hit &&
                  (burst_req || tail_req);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bready && bvalid;

  assign rem_nxt   = remaining - LSIZE'(beats);
  assign addr_nxt  = cur_addr +
                     (ADDR_WIDTH'(beats) << SZ);
  assign len_src   = take ? req_len : rem_nxt;
  assign beats_nxt = clip(len_src);

  assign ld_aw = (take && (req_len != '0)) ||
                 (b_hs && (rem_nxt != '0));

  assign wvalid     = (state == S_W) && !fifo_empty;
  assign fifo_rd_en = w_hs;
  assign wdata      = fifo_rdata;
  assign wstrb      = '1;
  assign awsize     = 3'(SZ);
  assign awburst    = 2'b01;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (take)
          state_nxt = (req_len == '0) ? S_DONE : S_AW;
      S_AW:
        if (aw_hs)
          state_nxt = S_W;
      S_W:
        if (w_hs && wlast)
          state_nxt = S_B;
      S_B:
        if (b_hs)
          state_nxt = (rem_nxt == '0) ? S_DONE : S_AW;
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      beats     <= '0;
      cnt       <= '0;
      fs_pend   <= 1'b0;
      resp      <= 1'b0;
      done      <= 1'b0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      awlen     <= '0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
      err       <= 1'b0;
    end else begin
      resp <= take;
      done <= (state_nxt == S_DONE);

      if (fs_hit)
        fs_pend <= 1'b0;
      else if (frame_start)
        fs_pend <= 1'b1;

      if (fs_hit) begin
        cur_addr <= frame_base;
        err      <= 1'b0;
      end

      if (take)
        remaining <= req_len;

      if (ld_aw) begin
        awvalid <= 1'b1;
        awaddr  <= take ? cur_addr : addr_nxt;
        awlen   <= 8'(beats_nxt - 1'b1);
        beats   <= beats_nxt;
      end else if (aw_hs) begin
        awvalid <= 1'b0;
      end

      // wlast is staged one beat ahead of the final handshake
      if (aw_hs) begin
        cnt   <= '0;
        wlast <= (beats == BW'(1));
      end else if (w_hs) begin
        cnt   <= cnt + 1'b1;
        wlast <= ({1'b0, cnt} + 2'd2) == {1'b0, beats};
      end

      if (w_hs && wlast)
        bready <= 1'b1;
      else if (b_hs)
        bready <= 1'b0;

      if (b_hs) begin
        cur_addr  <= addr_nxt;
        remaining <= rem_nxt;
        if (bresp != 2'b00)
          err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/vdma_wr_burst.md
VDMA_WR_BURST -- requirements
Module: vdma_wr_burst

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 Parameter DATA_WIDTH, default 64, FIFO/AXI data width; power of two, 8..1024.
REQ-003 Parameter LSIZE, default 9, width of req_len.
REQ-004 Parameter MAX_BURST, default 256, maximum beats per AXI burst (1..256).
REQ-005 clock  in  1  single clock for all logic.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 frame_start  in  1  pulse; reload write address from frame_base.
REQ-008 frame_base  in  ADDR_WIDTH  frame start byte address.
REQ-009 burst_req / tail_req  in  1 each  upstream request levels, held until resp.
REQ-010 req_len  in  LSIZE  beats requested; valid while a request is high.
REQ-011 resp  out  1  one-cycle acceptance pulse; done  out  1  one-cycle completion pulse.
REQ-012 fifo_rdata  in  DATA_WIDTH, fifo_empty  in  1, fifo_rd_en  out  1  show-ahead FIFO read port.
REQ-013 awaddr  out  ADDR_WIDTH, awlen  out  8, awsize  out  3, awburst  out  2, awvalid  out  1, awready  in  1.
REQ-014 wdata  out  DATA_WIDTH, wstrb  out  DATA_WIDTH/8, wlast  out  1, wvalid  out  1, wready  in  1.
REQ-015 bresp  in  2, bvalid  in  1, bready  out  1.
REQ-016 err  out  1  sticky write-response error flag.

Function
REQ-017 States: IDLE, AW, W, B, DONE; all outputs except wdata/wvalid/fifo_rd_en registered.
REQ-018 IDLE: burst_req or tail_req high -> latch remaining=req_len; next cycle resp=1 for exactly one cycle; go AW (or DONE if req_len==0, no AXI traffic).
REQ-019 burst_req and tail_req both high: treated as one request; single resp.
REQ-020 AW: awvalid=1, awaddr=cur_addr, awlen=beats-1 with beats=min(remaining,MAX_BURST); awsize=log2(DATA_WIDTH/8), awburst=2'b01, constant; awready -> W.
REQ-021 AW fields stable while awvalid=1 and awready=0.
REQ-022 W: wdata=fifo_rdata, wvalid=!fifo_empty, fifo_rd_en=wvalid&&wready, wstrb all ones; wvalid never asserted outside W.
REQ-023 Beat counter increments per wvalid&&wready; wlast=1 on final beat of current burst only; handshake with wlast -> B.
REQ-024 fifo_empty mid-burst: wvalid drops, counter holds, burst resumes without beat loss or duplication.
REQ-025 B: bready=1; on bvalid: cur_addr += beats*(DATA_WIDTH/8) (wraps modulo 2^ADDR_WIDTH), remaining -= beats; remaining!=0 -> AW, else DONE.
REQ-026 req_len > MAX_BURST is split into consecutive bursts; exactly one resp and one done per request.
REQ-027 bresp != 2'b00 sets err; burst sequence continues unchanged; err cleared only by frame_start or reset.
REQ-028 DONE: done=1 one cycle -> IDLE; new request not accepted in DONE cycle.
REQ-029 frame_start in IDLE: cur_addr=frame_base next cycle, err cleared; outside IDLE: held pending and applied on entry to IDLE, before next request acceptance.
REQ-030 No 4 KB boundary splitting; frame_base and burst sizes are 4 KB-consistent by system construction, unchecked.

Reset
REQ-031 rst_n low: state IDLE, cur_addr=0, remaining=0, pending frame_start cleared; resp, done, awvalid, wvalid, wlast, bready, fifo_rd_en, err all 0, awaddr=0, awlen=0.
REQ-032 Reset mid-burst aborts immediately; no completion of outstanding AXI transaction attempted.

Verification
REQ-033 frame_base=0x1000_0000, frame_start, burst_req len=200, awready/wready/bvalid always 1 -> resp 1 cycle, one AW awlen=199 addr 0x1000_0000, 200 beats, wlast on beat 200, done; next addr 0x1000_0640.
REQ-034 tail_req len=300 -> awlen=255 at base, then awlen=43 at base+0x800; single resp, single done after second B.
REQ-035 tail_req len=0 -> resp then done, no awvalid/wvalid.
REQ-036 fifo_empty toggled randomly, wready toggled randomly, len=16 -> 16 distinct FIFO words written in order, fifo_rd_en count=16.
REQ-037 bresp=2'b10 on first burst -> err=1, done still issued; frame_start -> err=0.
REQ-038 rst_n low during W beat 50 of 200 -> all outputs at reset values same cycle; next request starts at address 0.
